// File: rtl/spi_master_sched.sv
// Round-robin scheduler that shares one spi_master_drv between NUM_REQ packet requesters,
// forwarding framed packets and steering slave acks back to the current owner.
module spi_master_sched #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ACK_TIMEOUT = 4096,
  parameter int unsigned IDLE_GAP    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_vld_i,
  output logic [NUM_REQ-1:0]            req_rdy_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            ack_vld_o,
  output logic                          ack_last_o,
  output logic [DATA_WIDTH-1:0]         ack_data_o,
  output logic [NUM_REQ-1:0]            timeout_o,
  output logic                          busy_o,
  output logic [7:0]                    stray_ack_cnt_o,
  output logic [DATA_WIDTH-1:0]         master_wr_data_o,
  output logic                          master_wr_vld_o,
  input  logic                          slave_ack_vld_i,
  input  logic                          slave_ack_last_i,
  input  logic [DATA_WIDTH-1:0]         slave_ack_data_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned TMR_W = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
    S_GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      rdy_q, rdy_d;
  logic                    first_q, first_d;
  logic                    wait_q, wait_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [DATA_WIDTH-1:0]   mwr_data_q, mwr_data_d;
  logic                    mwr_vld_q, mwr_vld_d;
  logic [NUM_REQ-1:0]      ack_vld_q, ack_vld_d;
  logic                    ack_last_q, ack_last_d;
  logic [DATA_WIDTH-1:0]   ack_data_q, ack_data_d;
  logic [NUM_REQ-1:0]      timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        stray_q, stray_d;

  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];
  logic [DATA_WIDTH-1:0]   word;
  logic                    accept;
  logic                    pkt_done;
  logic                    next_wait;
  logic                    found;
  logic [IDX_W-1:0]        win;
  logic [IDX_W-1:0]        cand;

  // Unpacked view of the flat requester data bus
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign req_word[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    rdy_d      = rdy_q;
    first_d    = first_q;
    wait_d     = wait_q;
    len_d      = len_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    mwr_data_d = mwr_data_q;
    mwr_vld_d  = 1'b0;
    ack_vld_d  = '0;
    ack_last_d = 1'b0;
    ack_data_d = ack_data_q;
    timeout_d  = '0;
    stray_d    = stray_q;
    pkt_done   = 1'b0;
    next_wait  = wait_q;
    found      = 1'b0;
    win        = last_q;
    cand       = '0;
    word       = req_word[owner_q];
    accept     = |(req_vld_i & rdy_q);

    // Round-robin search starting just after the last winner
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!found && req_vld_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SEND;
          owner_d = win;
          last_d  = win;
          grant_d = NUM_REQ'(1) << win;
          rdy_d   = NUM_REQ'(1) << win;
          first_d = 1'b1;
        end
      end

      S_SEND: begin
        if (accept) begin
          mwr_vld_d  = 1'b1;
          mwr_data_d = word;
          if (first_q) begin
            first_d   = 1'b0;
            wait_d    = word[31];
            len_d     = word[LEN_W-1:0];
            next_wait = word[31];
            pkt_done  = (word[LEN_W-1:0] == '0);
          end else begin
            len_d    = len_q - LEN_W'(1);
            pkt_done = (len_q == LEN_W'(1));
          end
          if (pkt_done) begin
            rdy_d   = '0;
            timer_d = '0;
            gap_d   = '0;
            state_d = next_wait ? S_WAIT_ACK : S_GAP;
          end
        end
      end

      S_WAIT_ACK: begin
        timer_d = timer_q + TMR_W'(1);
        if (slave_ack_vld_i) begin
          ack_vld_d  = grant_q;
          ack_last_d = slave_ack_last_i;
          ack_data_d = slave_ack_data_i;
        end
        // A final ack on the deadline cycle takes precedence over the timeout
        if (slave_ack_vld_i && slave_ack_last_i) begin
          state_d = S_GAP;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          timeout_d = grant_q;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(IDLE_GAP - 1)) begin
          gap_d   = '0;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (slave_ack_vld_i && (state_q != S_WAIT_ACK) && (stray_q != '1)) begin
      stray_d = stray_q + CNT_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      grant_q    <= '0;
      rdy_q      <= '0;
      first_q    <= 1'b0;
      wait_q     <= 1'b0;
      len_q      <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      mwr_data_q <= '0;
      mwr_vld_q  <= 1'b0;
      ack_vld_q  <= '0;
      ack_last_q <= 1'b0;
      ack_data_q <= '0;
      timeout_q  <= '0;
      busy_q     <= 1'b0;
      stray_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      rdy_q      <= rdy_d;
      first_q    <= first_d;
      wait_q     <= wait_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      mwr_data_q <= mwr_data_d;
      mwr_vld_q  <= mwr_vld_d;
      ack_vld_q  <= ack_vld_d;
      ack_last_q <= ack_last_d;
      ack_data_q <= ack_data_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      stray_q    <= stray_d;
    end
  end

  assign req_rdy_o        = rdy_q;
  assign grant_o          = grant_q;
  assign ack_vld_o        = ack_vld_q;
  assign ack_last_o       = ack_last_q;
  assign ack_data_o       = ack_data_q;
  assign timeout_o        = timeout_q;
  assign busy_o           = busy_q;
  assign stray_ack_cnt_o  = stray_q;
  assign master_wr_data_o = mwr_data_q;
  assign master_wr_vld_o  = mwr_vld_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched: writes, contention, reads, timeout, stray acks, reset abort.
module tb_spi_master_sched;

  localparam int unsigned NR  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 16;
  localparam int unsigned GAP = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0]    req_vld_i = '0;
  logic [NR-1:0]    req_rdy_o;
  logic [NR-1:0]    grant_o;
  logic [NR-1:0]    ack_vld_o;
  logic             ack_last_o;
  logic [DW-1:0]    ack_data_o;
  logic [NR-1:0]    timeout_o;
  logic             busy_o;
  logic [7:0]       stray_ack_cnt_o;
  logic [DW-1:0]    master_wr_data_o;
  logic             master_wr_vld_o;
  logic             slave_ack_vld_i = 1'b0;
  logic             slave_ack_last_i = 1'b0;
  logic [DW-1:0]    slave_ack_data_i = '0;

  spi_master_sched #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO), .IDLE_GAP(GAP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_data_i(req_data_i), .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
    .grant_o(grant_o), .ack_vld_o(ack_vld_o), .ack_last_o(ack_last_o),
    .ack_data_o(ack_data_o), .timeout_o(timeout_o), .busy_o(busy_o),
    .stray_ack_cnt_o(stray_ack_cnt_o),
    .master_wr_data_o(master_wr_data_o), .master_wr_vld_o(master_wr_vld_o),
    .slave_ack_vld_i(slave_ack_vld_i), .slave_ack_last_i(slave_ack_last_i),
    .slave_ack_data_i(slave_ack_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Edge-stamped observation of the master write port, timeouts, busy and owner-0 acks
  int              cyc = 0;
  int              mon_cyc[$];
  logic [DW-1:0]   mon_data[$];
  logic [NR-1:0]   mon_gnt[$];
  int              to_cyc[$];
  logic [NR-1:0]   to_val[$];
  int              ack0_cnt = 0;
  int              busy_fall = -1;
  logic            busy_prev = 1'b0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (master_wr_vld_o) begin
      mon_cyc.push_back(cyc);
      mon_data.push_back(master_wr_data_o);
      mon_gnt.push_back(grant_o);
    end
    if (timeout_o != '0) begin
      to_cyc.push_back(cyc);
      to_val.push_back(timeout_o);
    end
    if (ack_vld_o[0]) ack0_cnt++;
    if (busy_prev && !busy_o) busy_fall = cyc;
    busy_prev = busy_o;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int first_hs;
  int last_hs;

  // Present queued words on both requesters until drained, budget spent, or max_hs handshakes
  task automatic run_reqs(input int budget, input int max_hs);
    int n = 0;
    int nhs = 0;
    logic [NR-1:0] hs;
    first_hs = -1;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget && nhs < max_hs) begin
      req_vld_i  = {q1.size() > 0, q0.size() > 0};
      req_data_i = {(q1.size() > 0) ? q1[0] : 32'h0, (q0.size() > 0) ? q0[0] : 32'h0};
      hs = req_vld_i & req_rdy_o;
      if (hs != '0) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      tick();
      if (hs[0]) begin void'(q0.pop_front()); nhs++; end
      if (hs[1]) begin void'(q1.pop_front()); nhs++; end
      n++;
    end
    req_vld_i = '0;
    check("req_drain", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check("idle_wait", 64'(n < budget), 64'd1);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, 64'(grant_o), 64'd0);
    check({tag, "_rdy"}, 64'(req_rdy_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_wvld"}, 64'(master_wr_vld_o), 64'd0);
    check({tag, "_wdata"}, 64'(master_wr_data_o), 64'd0);
    check({tag, "_ackv"}, 64'(ack_vld_o), 64'd0);
    check({tag, "_ackl"}, 64'(ack_last_o), 64'd0);
    check({tag, "_to"}, 64'(timeout_o), 64'd0);
    check({tag, "_stray"}, 64'(stray_ack_cnt_o), 64'd0);
  endtask

  logic [DW-1:0] e1d [3] = '{32'h0000_0002, 32'h0000_000A, 32'h0000_000B};
  logic [DW-1:0] e2d [4] = '{32'h0010_0000, 32'h0020_0000, 32'h0011_0000, 32'h0021_0000};
  logic [NR-1:0] e2g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [DW-1:0] e3d [3] = '{32'h0000_0111, 32'h0000_0222, 32'h0000_0333};

  initial begin
    int b;
    int tb0;
    int a0;

    // Reset state
    rst_i = 1'b1;
    tick(); tick();
    check_zero("rst");
    rst_i = 1'b0;
    tick();

    // 1. Single write, no ack
    b  = mon_data.size();
    q0 = {e1d[0], e1d[1], e1d[2]};
    run_reqs(100, 100);
    check("t1_rdy_drop", 64'(req_rdy_o), 64'd0);
    check("t1_grant_held", 64'(grant_o), 64'b01);
    wait_idle(100);
    check("t1_count", 64'(mon_data.size() - b), 64'd3);
    if (mon_data.size() - b == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t1_data%0d", i), 64'(mon_data[b+i]), 64'(e1d[i]));
        check($sformatf("t1_cyc%0d", i), 64'(mon_cyc[b+i]), 64'(first_hs + 1 + i));
      end
      check("t1_busy_fall", 64'(busy_fall), 64'(mon_cyc[b+2] + int'(GAP)));
    end
    check("t1_grant_clr", 64'(grant_o), 64'd0);

    // 2. Contention with priority restored by reset
    rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
    b  = mon_data.size();
    q0 = {e2d[0], e2d[2]};
    q1 = {e2d[1], e2d[3]};
    run_reqs(400, 100);
    wait_idle(100);
    check("t2_count", 64'(mon_data.size() - b), 64'd4);
    if (mon_data.size() - b == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_data%0d", i), 64'(mon_data[b+i]), 64'(e2d[i]));
        check($sformatf("t2_grant%0d", i), 64'(mon_gnt[b+i]), 64'(e2g[i]));
        if (i > 0)
          check($sformatf("t2_gap%0d", i),
                64'((mon_cyc[b+i] - mon_cyc[b+i-1] - 1) >= int'(GAP)), 64'd1);
      end
    end

    // 3. Read with three acks returned to requester 1
    a0 = ack0_cnt;
    tb0 = to_cyc.size();
    q1 = {32'h8000_0000};
    run_reqs(100, 100);
    check("t3_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      slave_ack_vld_i  = 1'b1;
      slave_ack_last_i = (i == 2);
      slave_ack_data_i = e3d[i];
      tick();
      check($sformatf("t3_ackv%0d", i), 64'(ack_vld_o), 64'b10);
      check($sformatf("t3_ackd%0d", i), 64'(ack_data_o), 64'(e3d[i]));
      check($sformatf("t3_ackl%0d", i), 64'(ack_last_o), 64'(i == 2));
    end
    slave_ack_vld_i  = 1'b0;
    slave_ack_last_i = 1'b0;
    tick();
    check("t3_ackv_off", 64'(ack_vld_o), 64'd0);
    wait_idle(100);
    check("t3_ack0", 64'(ack0_cnt - a0), 64'd0);
    check("t3_stray", 64'(stray_ack_cnt_o), 64'd0);
    check("t3_no_to", 64'(to_cyc.size() - tb0), 64'd0);

    // 4. Ack timeout, then another requester is served
    b   = mon_data.size();
    tb0 = to_cyc.size();
    q0  = {32'h8000_0000};
    run_reqs(100, 100);
    wait_idle(200);
    check("t4_to_count", 64'(to_cyc.size() - tb0), 64'd1);
    if (to_cyc.size() - tb0 == 1 && mon_data.size() > b) begin
      check("t4_to_val", 64'(to_val[tb0]), 64'b01);
      check("t4_to_cyc", 64'(to_cyc[tb0]), 64'(mon_cyc[b] + int'(TO)));
    end
    q1 = {32'h0012_0000};
    run_reqs(100, 100);
    wait_idle(100);
    check("t4_next_count", 64'(mon_data.size() - b), 64'd2);
    if (mon_data.size() - b == 2) begin
      check("t4_next_grant", 64'(mon_gnt[b+1]), 64'b10);
      check("t4_next_data", 64'(mon_data[b+1]), 64'h0012_0000);
    end

    // 5. Stray acks saturate; final ack on the deadline cycle beats the timeout
    a0 = ack0_cnt;
    slave_ack_vld_i = 1'b1;
    repeat (100) tick();
    check("t5_stray100", 64'(stray_ack_cnt_o), 64'd100);
    repeat (200) tick();
    slave_ack_vld_i = 1'b0;
    tick();
    check("t5_stray_sat", 64'(stray_ack_cnt_o), 64'd255);
    check("t5_no_ackv", 64'(ack0_cnt - a0), 64'd0);
    tb0 = to_cyc.size();
    q0  = {32'h8000_0000};
    run_reqs(100, 100);
    repeat (TO - 1) tick();
    slave_ack_vld_i  = 1'b1;
    slave_ack_last_i = 1'b1;
    slave_ack_data_i = 32'hDEAD_BEEF;
    tick();
    slave_ack_vld_i  = 1'b0;
    slave_ack_last_i = 1'b0;
    check("t5_race_ackv", 64'(ack_vld_o), 64'b01);
    check("t5_race_ackl", 64'(ack_last_o), 64'd1);
    check("t5_race_data", 64'(ack_data_o), 64'hDEAD_BEEF);
    check("t5_race_to", 64'(timeout_o), 64'd0);
    wait_idle(100);
    check("t5_race_no_to", 64'(to_cyc.size() - tb0), 64'd0);

    // 6. Reset after 2 of 5 words; req0 regains priority
    b  = mon_data.size();
    q0 = {32'h0000_0004, 32'h1, 32'h2, 32'h3, 32'h4};
    run_reqs(100, 2);
    check("t6_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    q0.delete();
    tick();
    check_zero("t6");
    rst_i = 1'b0;
    check("t6_partial", 64'(mon_data.size() - b), 64'd2);
    q0 = {32'h0013_0000};
    q1 = {32'h0023_0000};
    run_reqs(200, 100);
    wait_idle(100);
    check("t6_count", 64'(mon_data.size() - b), 64'd4);
    if (mon_data.size() - b == 4) begin
      check("t6_grant0", 64'(mon_gnt[b+2]), 64'b01);
      check("t6_data0", 64'(mon_data[b+2]), 64'h0013_0000);
      check("t6_grant1", 64'(mon_gnt[b+3]), 64'b10);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
